// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low/full-speed transmit packet path.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    PID  = 3'd2,
    DATA = 3'd3,
    CRC  = 3'd4,
    EOP  = 3'd5,
    DONE = 3'd6
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'h80;

  localparam logic [3:0]  PID_ACK   = 4'b0010;
  localparam logic [3:0]  PID_NAK   = 4'b1010;
  localparam logic [3:0]  PID_DATA0 = 4'b0011;
  localparam logic [3:0]  PID_DATA1 = 4'b1011;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // The PID goes on the wire with its own complement in the upper nibble.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_tx_pkt_ctrl_if.sv
// Signal bundle between the packet controller, its byte source, the CRC16 register and the encoder.
interface usb_tx_pkt_ctrl_if;

  logic        tx_start;
  logic [3:0]  tx_pid;
  logic        tx_has_data;
  logic        tx_zlp;
  logic [7:0]  data_byte;
  logic        data_valid;
  logic        data_last;
  logic        data_ready;
  logic        bit_strobe;
  logic        tx_hold;
  logic [15:0] crc_16;
  logic        crc_clear;
  logic        crc_enable;
  logic        tx_out_bit;
  logic        tx_active;
  logic        eop_req;
  logic        tx_done;
  logic        tx_underrun;

  modport master (
    input  tx_start, tx_pid, tx_has_data, tx_zlp,
    input  data_byte, data_valid, data_last,
    input  bit_strobe, tx_hold, crc_16,
    output data_ready, crc_clear, crc_enable, tx_out_bit,
    output tx_active, eop_req, tx_done, tx_underrun
  );

  modport slave (
    output tx_start, tx_pid, tx_has_data, tx_zlp,
    output data_byte, data_valid, data_last,
    output bit_strobe, tx_hold, crc_16,
    input  data_ready, crc_clear, crc_enable, tx_out_bit,
    input  tx_active, eop_req, tx_done, tx_underrun
  );

endinterface

// File: rtl/usb_tx_pkt_ctrl.sv
// Bit-level sequencer for one USB transmit packet: SYNC, PID, payload, CRC16, EOP.
module usb_tx_pkt_ctrl
  import usb_tx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned EOP_BITS  = 3
)
(
  input  logic              clk,
  input  logic              n_rst,
  usb_tx_pkt_ctrl_if.master bus
);

  localparam logic [3:0] EOP_LAST = 4'(EOP_BITS - 1);

  tx_state_t   state, next_state;
  logic [7:0]  shreg, shreg_n;
  logic [3:0]  cnt, cnt_n;
  logic [3:0]  pid_q, pid_n;
  logic        has_data_q, has_data_n;
  logic        zlp_q, zlp_n;
  logic        last_q, last_n;
  logic        underrun_q, underrun_n;

  logic        advance;
  logic        byte_end;
  logic        need_byte;
  logic        data_ready_c;
  logic        crc_clear_c;
  logic        crc_enable_c;
  logic        out_bit_c;
  logic        eop_req_c;
  logic        tx_done_c;
  logic        tx_underrun_c;

  assign advance  = bus.bit_strobe && !bus.tx_hold;
  assign byte_end = advance && (cnt[2:0] == 3'd7);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      shreg      <= 8'h00;
      cnt        <= 4'd0;
      pid_q      <= 4'd0;
      has_data_q <= 1'b0;
      zlp_q      <= 1'b0;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= next_state;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      pid_q      <= pid_n;
      has_data_q <= has_data_n;
      zlp_q      <= zlp_n;
      last_q     <= last_n;
      underrun_q <= underrun_n;
    end
  end

  always_comb begin
    next_state    = state;
    shreg_n       = shreg;
    cnt_n         = cnt;
    pid_n         = pid_q;
    has_data_n    = has_data_q;
    zlp_n         = zlp_q;
    last_n        = last_q;
    underrun_n    = underrun_q;
    need_byte     = 1'b0;
    data_ready_c  = 1'b0;
    crc_clear_c   = 1'b0;
    crc_enable_c  = 1'b0;
    out_bit_c     = 1'b1;
    eop_req_c     = 1'b0;
    tx_done_c     = 1'b0;
    tx_underrun_c = 1'b0;

    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          crc_clear_c = 1'b1;
          pid_n       = bus.tx_pid;
          has_data_n  = bus.tx_has_data;
          zlp_n       = bus.tx_zlp;
          last_n      = 1'b0;
          underrun_n  = 1'b0;
          shreg_n     = SYNC_BYTE;
          cnt_n       = 4'd0;
          next_state  = SYNC;
        end
      end

      SYNC: begin
        out_bit_c = shreg[0];
        if (advance) begin
          shreg_n = {1'b0, shreg[7:1]};
          cnt_n   = cnt + 4'd1;
        end
        if (byte_end) begin
          shreg_n    = pid_byte(pid_q);
          cnt_n      = 4'd0;
          next_state = PID;
        end
      end

      PID: begin
        out_bit_c = shreg[0];
        if (advance) begin
          shreg_n = {1'b0, shreg[7:1]};
          cnt_n   = cnt + 4'd1;
        end
        if (byte_end) begin
          cnt_n = 4'd0;
          if (!has_data_q) begin
            next_state = EOP;
          end else if (zlp_q) begin
            next_state = CRC;
          end else begin
            need_byte = 1'b1;
          end
        end
      end

      // Only payload bits are folded into the CRC register.
      DATA: begin
        crc_enable_c = 1'b1;
        out_bit_c    = shreg[0];
        if (advance) begin
          shreg_n = {1'b0, shreg[7:1]};
          cnt_n   = cnt + 4'd1;
        end
        if (byte_end) begin
          cnt_n = 4'd0;
          if (last_q) begin
            next_state = CRC;
          end else begin
            need_byte = 1'b1;
          end
        end
      end

      // CRC register is frozen here; its complement goes out MSB first.
      CRC: begin
        out_bit_c = ~bus.crc_16[4'd15 - cnt];
        if (advance) begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            cnt_n      = 4'd0;
            next_state = EOP;
          end
        end
      end

      // The encoder never stuffs during SE0, so EOP counts raw strobes.
      EOP: begin
        eop_req_c = 1'b1;
        if (bus.bit_strobe) begin
          cnt_n = cnt + 4'd1;
          if (cnt == EOP_LAST) begin
            cnt_n      = 4'd0;
            next_state = DONE;
          end
        end
      end

      DONE: begin
        tx_done_c  = !underrun_q;
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    // A starved byte boundary aborts straight to EOP, leaving the packet corrupt.
    if (need_byte) begin
      data_ready_c = 1'b1;
      if (bus.data_valid) begin
        shreg_n    = bus.data_byte;
        last_n     = bus.data_last;
        next_state = DATA;
      end else begin
        tx_underrun_c = 1'b1;
        underrun_n    = 1'b1;
        next_state    = EOP;
      end
    end
  end

  assign bus.data_ready  = data_ready_c;
  assign bus.crc_clear   = crc_clear_c;
  assign bus.crc_enable  = crc_enable_c;
  assign bus.tx_out_bit  = out_bit_c;
  assign bus.eop_req     = eop_req_c;
  assign bus.tx_done     = tx_done_c;
  assign bus.tx_underrun = tx_underrun_c;
  assign bus.tx_active   = (state == SYNC) || (state == PID) || (state == DATA) ||
                           (state == CRC)  || (state == EOP);

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Scoreboard bench for usb_tx_pkt_ctrl with a behavioural CRC16 register and packet model.
module tb_usb_tx_pkt_ctrl;
  import usb_tx_pkg::*;

  localparam int EOP_BITS   = 3;
  localparam int STROBE_DIV = 4;
  localparam int PKT_BUDGET = 3000;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    int eop_strobes;
    int crc_adv;
    int ready;
    int done;
    int underrun;
  } pkt_exp_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_tx_pkt_ctrl_if bus();

  usb_tx_pkt_ctrl #(.SYNC_BYTE(8'h80), .EOP_BITS(EOP_BITS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  logic     exp_bits[$];
  pkt_exp_t exp_pkt[$];
  int       checks = 0;
  int       errors = 0;

  logic [7:0] pl[$];
  int         n_avail = 0;
  int         pl_idx = 0;
  bit         consumed = 1'b0;
  int         hold_budget = 0;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return fb ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
  endfunction

  function automatic logic [15:0] ref_crc(input bytes_t d);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    foreach (d[i]) begin
      b = d[i];
      for (int k = 0; k < 8; k++) c = crc_step(c, b[k]);
    end
    return c;
  endfunction

  // Stand-in for the TX CRC16 register the controller steers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      bus.crc_16 <= 16'hFFFF;
    else if (bus.crc_clear)
      bus.crc_16 <= CRC16_INIT;
    else if (bus.crc_enable && bus.bit_strobe && !bus.tx_hold)
      bus.crc_16 <= crc_step(bus.crc_16, bus.tx_out_bit);
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Encoder and byte-source side: strobes every STROBE_DIV clocks, random holds, payload feed.
  initial begin
    int cyc;
    cyc = 0;
    bus.bit_strobe = 1'b0;
    bus.tx_hold    = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_byte  = 8'h00;
    bus.data_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (consumed) pl_idx++;
      consumed = 1'b0;
      cyc++;
      bus.bit_strobe = ((cyc % STROBE_DIV) == 0);
      if (bus.bit_strobe)
        bus.tx_hold = (hold_budget > 0) && bus.tx_active && !bus.eop_req &&
                      ($urandom_range(0, 3) == 0);
      else
        bus.tx_hold = ($urandom_range(0, 3) == 0);
      if (bus.bit_strobe && bus.tx_hold) hold_budget--;
      if (pl_idx < n_avail) begin
        bus.data_valid = 1'b1;
        bus.data_byte  = pl[pl_idx];
        bus.data_last  = (pl_idx == pl.size() - 1);
      end else begin
        bus.data_valid = 1'b0;
        bus.data_byte  = 8'($urandom);
        bus.data_last  = 1'($urandom);
      end
      #1;
      if (bus.data_ready && bus.data_valid) consumed = 1'b1;
    end
  end

  // Monitor: pops one expected bit per advance, and one packet record per packet end.
  initial begin
    int       bitn, eop_s, crc_a, rdy, dn, un;
    bit       prev_active, in_eop, un_prev, adv;
    logic     want;
    pkt_exp_t e;
    bitn = 0; eop_s = 0; crc_a = 0; rdy = 0; dn = 0; un = 0;
    prev_active = 1'b0; in_eop = 1'b0; un_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!n_rst) begin
        bitn = 0; eop_s = 0; crc_a = 0; rdy = 0; dn = 0; un = 0;
        prev_active = 1'b0; in_eop = 1'b0; un_prev = 1'b0;
        continue;
      end
      adv = bus.bit_strobe && !bus.tx_hold;
      if (un_prev) checkOutput("eop_after_underrun", 32'(bus.eop_req), 32'd1);
      un_prev = bus.tx_underrun;
      if (bus.tx_active && !bus.eop_req && adv) begin
        if (exp_bits.size() == 0) begin
          checkOutput("bit_expected", 32'(exp_bits.size()), 32'd1);
        end else begin
          want = exp_bits.pop_front();
          checkOutput($sformatf("bit%0d", bitn), 32'(bus.tx_out_bit), 32'(want));
        end
        bitn++;
      end
      if (bus.eop_req && !in_eop) begin
        in_eop = 1'b1;
        checkOutput("bits_left_at_eop", 32'(exp_bits.size()), 32'd0);
      end
      if (bus.eop_req && bus.bit_strobe) eop_s++;
      if (bus.crc_enable && adv) crc_a++;
      if (bus.data_ready) rdy++;
      if (bus.tx_done) dn++;
      if (bus.tx_underrun) un++;
      if (prev_active && !bus.tx_active) begin
        if (exp_pkt.size() == 0) begin
          checkOutput("pkt_expected", 32'(exp_pkt.size()), 32'd1);
        end else begin
          e = exp_pkt.pop_front();
          checkOutput("eop_strobes", 32'(eop_s), 32'(e.eop_strobes));
          checkOutput("crc_enable_advances", 32'(crc_a), 32'(e.crc_adv));
          checkOutput("data_ready_count", 32'(rdy), 32'(e.ready));
          checkOutput("tx_done_count", 32'(dn), 32'(e.done));
          checkOutput("tx_underrun_count", 32'(un), 32'(e.underrun));
        end
        bitn = 0; eop_s = 0; crc_a = 0; rdy = 0; dn = 0; un = 0;
        in_eop = 1'b0;
      end
      prev_active = bus.tx_active;
    end
  end

  task automatic startPacket(input logic [3:0] pid, input bit has_data, input bit zlp,
                             input bytes_t d, input int avail, input int holds);
    logic [7:0]  s;
    logic [7:0]  b;
    logic [15:0] c;
    bytes_t      sent;
    int          und;
    pkt_exp_t    e;
    s = 8'h80;
    for (int k = 0; k < 8; k++) exp_bits.push_back(s[k]);
    s = {~pid, pid};
    for (int k = 0; k < 8; k++) exp_bits.push_back(s[k]);
    und = 0;
    if (has_data && !zlp) begin
      if (avail >= d.size()) begin
        foreach (d[i]) sent.push_back(d[i]);
      end else begin
        und = 1;
        for (int i = 0; i < avail; i++) sent.push_back(d[i]);
      end
      foreach (sent[i]) begin
        b = sent[i];
        for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
      end
    end
    if (has_data && und == 0) begin
      c = ~ref_crc(sent);
      for (int k = 15; k >= 0; k--) exp_bits.push_back(c[k]);
    end
    e.eop_strobes = EOP_BITS;
    e.crc_adv     = 8 * sent.size();
    e.ready       = (has_data && !zlp) ? sent.size() + und : 0;
    e.done        = 1 - und;
    e.underrun    = und;
    exp_pkt.push_back(e);

    pl = d;
    n_avail = avail;
    pl_idx = 0;
    consumed = 1'b0;
    hold_budget = holds;

    @(negedge clk);
    bus.tx_start    = 1'b1;
    bus.tx_pid      = pid;
    bus.tx_has_data = has_data;
    bus.tx_zlp      = zlp;
    #1;
    checkOutput("crc_clear_on_start", 32'(bus.crc_clear), 32'd1);
    @(negedge clk);
    bus.tx_start    = 1'b0;
    bus.tx_pid      = 4'($urandom);
    bus.tx_has_data = 1'($urandom);
    bus.tx_zlp      = 1'($urandom);
  endtask

  task automatic waitPacketEnd(input bit poke);
    bit seen, ended;
    int poke_at;
    seen = 1'b0;
    ended = 1'b0;
    poke_at = $urandom_range(3, 60);
    for (int c = 0; c < PKT_BUDGET && !ended; c++) begin
      @(negedge clk);
      bus.tx_start = poke && (c == poke_at) && bus.tx_active;
      bus.tx_pid   = 4'($urandom);
      #1;
      if (bus.tx_active) seen = 1'b1;
      else if (seen) ended = 1'b1;
    end
    bus.tx_start = 1'b0;
    if (!ended) begin
      checkOutput("packet_end_timeout", 32'(ended), 32'd1);
      exp_bits.delete();
      exp_pkt.delete();
    end
    repeat (2) @(negedge clk);
    #1;
    checkOutput("bits_drained", 32'(exp_bits.size()), 32'd0);
    n_avail = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] pid, input bit has_data, input bit zlp,
                               input bytes_t d, input int avail, input int holds, input bit poke);
    startPacket(pid, has_data, zlp, d, avail, holds);
    waitPacketEnd(poke);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tx_out_bit"},  32'(bus.tx_out_bit),  32'd1);
    checkOutput({tag, "_tx_active"},   32'(bus.tx_active),   32'd0);
    checkOutput({tag, "_eop_req"},     32'(bus.eop_req),     32'd0);
    checkOutput({tag, "_crc_enable"},  32'(bus.crc_enable),  32'd0);
    checkOutput({tag, "_crc_clear"},   32'(bus.crc_clear),   32'd0);
    checkOutput({tag, "_data_ready"},  32'(bus.data_ready),  32'd0);
    checkOutput({tag, "_tx_done"},     32'(bus.tx_done),     32'd0);
    checkOutput({tag, "_tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
  endtask

  initial begin
    bytes_t empty_q, q2, qu, q6, qr;
    bit     found;
    int     kind, n, avail;
    logic [3:0] pid;

    n_rst = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_pid = 4'd0;
    bus.tx_has_data = 1'b0;
    bus.tx_zlp = 1'b0;
    q2 = '{8'hA5, 8'h01};
    qu = '{8'h3C, 8'h7E};

    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("rst");
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] ACK handshake");
    applyStimulus(PID_ACK, 1'b0, 1'b0, empty_q, 0, 0, 1'b0);
    $display("[TB] DATA0 zero-length");
    applyStimulus(PID_DATA0, 1'b1, 1'b1, empty_q, 0, 0, 1'b0);
    $display("[TB] DATA1 two bytes");
    applyStimulus(PID_DATA1, 1'b1, 1'b0, q2, 2, 0, 1'b0);
    $display("[TB] DATA1 two bytes with holds");
    applyStimulus(PID_DATA1, 1'b1, 1'b0, q2, 2, 3, 1'b0);
    $display("[TB] underrun after first byte");
    applyStimulus(PID_DATA0, 1'b1, 1'b0, qu, 1, 0, 1'b0);

    $display("[TB] reset mid-DATA");
    for (int i = 0; i < 6; i++) q6.push_back(8'($urandom));
    startPacket(PID_DATA0, 1'b1, 1'b0, q6, 6, 0);
    found = 1'b0;
    for (int c = 0; c < PKT_BUDGET && !found; c++) begin
      @(negedge clk);
      #1;
      if (bus.crc_enable) found = 1'b1;
    end
    checkOutput("reached_data", 32'(found), 32'd1);
    repeat (10) @(negedge clk);
    n_rst = 1'b0;
    #1;
    checkResetOutputs("midrst");
    exp_bits.delete();
    exp_pkt.delete();
    n_avail = 0;
    pl_idx = 0;
    consumed = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(PID_DATA1, 1'b1, 1'b0, q2, 2, 0, 1'b0);

    $display("[TB] random packets");
    for (int p = 0; p < 12; p++) begin
      kind = $urandom_range(0, 3);
      qr.delete();
      case (kind)
        0: begin
          pid = ($urandom_range(0, 1) == 0) ? PID_ACK : PID_NAK;
          applyStimulus(pid, 1'b0, 1'($urandom), empty_q, 0, $urandom_range(0, 4), 1'b1);
        end
        1: begin
          pid = ($urandom_range(0, 1) == 0) ? PID_DATA0 : PID_DATA1;
          applyStimulus(pid, 1'b1, 1'b1, empty_q, 0, $urandom_range(0, 4), 1'b1);
        end
        default: begin
          pid = ($urandom_range(0, 1) == 0) ? PID_DATA0 : PID_DATA1;
          n = $urandom_range(1, 5);
          for (int i = 0; i < n; i++) qr.push_back(8'($urandom));
          avail = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : n;
          applyStimulus(pid, 1'b1, 1'b0, qr, avail, $urandom_range(0, 4), 1'b1);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
